// File: rtl/hazard_control_if.sv
// Hazard control bus: ID/EX hazard sources in, pipeline enables/flushes and
// statistics out. The slave side is the hazard control unit; the master side
// is the pipeline that feeds it and obeys its enables.
interface hazard_control_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] IF_ID_RS1;
  logic [REG_ADDR_W-1:0] IF_ID_RS2;
  logic                  IF_ID_UseRS1;
  logic                  IF_ID_UseRS2;
  logic                  ID_EX_MemRead;
  logic [REG_ADDR_W-1:0] ID_EX_Rd;
  logic                  EX_BranchTaken;
  logic                  Mem_Busy;
  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Flush;
  logic                  Pipe_Hold;
  logic [CNT_W-1:0]      Stall_Count;
  logic [CNT_W-1:0]      Flush_Count;
  logic [CNT_W-1:0]      Hold_Count;

  modport master (
    output IF_ID_RS1, IF_ID_RS2, IF_ID_UseRS1, IF_ID_UseRS2,
           ID_EX_MemRead, ID_EX_Rd, EX_BranchTaken, Mem_Busy,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold,
           Stall_Count, Flush_Count, Hold_Count
  );

  modport slave (
    input  IF_ID_RS1, IF_ID_RS2, IF_ID_UseRS1, IF_ID_UseRS2,
           ID_EX_MemRead, ID_EX_Rd, EX_BranchTaken, Mem_Busy,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold,
           Stall_Count, Flush_Count, Hold_Count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for hazards forwarding cannot cover: load-use
// bubbles, taken-branch squash and data-memory wait (full hold).
// Priority each cycle: reset, Mem_Busy, EX_BranchTaken, LU_STALL, load-use.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined;
// otherwise the counter ports are tied to zero.
module hazard_control_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  hazard_control_if.slave hz
);
  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  localparam logic [REG_ADDR_W-1:0] REG_X0     = '0;
  localparam logic [CNT_W-1:0]      CNT_ZERO   = '0;
  localparam logic [3:0]            BUBBLES_P1 = 4'(STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] remain, remain_nxt;
  logic       lu;

  // A load in EX writing a non-x0 register that the ID instruction reads
  assign lu = hz.ID_EX_MemRead && (hz.ID_EX_Rd != REG_X0) &&
              ((hz.IF_ID_UseRS1 && (hz.ID_EX_Rd == hz.IF_ID_RS1)) ||
               (hz.IF_ID_UseRS2 && (hz.ID_EX_Rd == hz.IF_ID_RS2)));

  // State and remaining-bubble register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      remain <= 4'd0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  // Prioritised next-state and combinational pipeline controls
  always_comb begin
    state_nxt      = state;
    remain_nxt     = remain;
    hz.PCWrite     = 1'b1;
    hz.IF_ID_Write = 1'b1;
    hz.IF_ID_Flush = 1'b0;
    hz.ID_EX_Flush = 1'b0;
    hz.Pipe_Hold   = 1'b0;
    if (reset) begin
      hz.PCWrite     = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.IF_ID_Flush = 1'b1;
      hz.ID_EX_Flush = 1'b1;
    end else if (hz.Mem_Busy) begin
      // Freeze everything; the stall is stretched, no bubble is consumed
      hz.PCWrite     = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.Pipe_Hold   = 1'b1;
    end else if (hz.EX_BranchTaken) begin
      // Squash wins over load-use: the dependent consumer is discarded
      hz.IF_ID_Flush = 1'b1;
      hz.ID_EX_Flush = 1'b1;
      state_nxt      = RUN;
      remain_nxt     = 4'd0;
    end else if (state == LU_STALL) begin
      hz.PCWrite     = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.ID_EX_Flush = 1'b1;
      if (remain == 4'd1) begin
        state_nxt  = RUN;
        remain_nxt = 4'd0;
      end else begin
        remain_nxt = remain - 4'd1;
      end
    end else if (lu) begin
      hz.PCWrite     = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.ID_EX_Flush = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_nxt  = LU_STALL;
        remain_nxt = BUBBLES_P1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt, flush_cnt, hold_cnt;
  logic             stall_evt, flush_evt, hold_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  assign stall_evt = !hz.Mem_Busy && !hz.EX_BranchTaken && ((state == LU_STALL) || lu);
  assign flush_evt = !hz.Mem_Busy && hz.EX_BranchTaken;
  assign hold_evt  = hz.Mem_Busy;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= CNT_ZERO;
      flush_cnt <= CNT_ZERO;
      hold_cnt  <= CNT_ZERO;
    end else begin
      if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
      if (hold_evt)  hold_cnt  <= sat_inc(hold_cnt);
    end
  end

  assign hz.Stall_Count = stall_cnt;
  assign hz.Flush_Count = flush_cnt;
  assign hz.Hold_Count  = hold_cnt;
`else
  assign hz.Stall_Count = CNT_ZERO;
  assign hz.Flush_Count = CNT_ZERO;
  assign hz.Hold_Count  = CNT_ZERO;
`endif
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush controller paired with the pipeline's forwarding logic. It handles every hazard that forwarding cannot resolve.
- Hazards handled: load-use (bubble insertion), taken-branch squash, and data-memory wait (full pipeline hold).
- Sits between the ID stage and the pipeline registers. Drives PC write enable, IF/ID write enable, IF/ID and ID/EX flushes, and a global hold for EX/MEM and MEM/WB.

Parameters:
- STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..15)
- REG_ADDR_W, 5, register address width
- CNT_W, 16, width of statistics counters

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- IF_ID_RS1  input  REG_ADDR_W  rs1 of instruction in ID
- IF_ID_RS2  input  REG_ADDR_W  rs2 of instruction in ID
- IF_ID_UseRS1  input  1  ID instruction reads rs1
- IF_ID_UseRS2  input  1  ID instruction reads rs2
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_Rd  input  REG_ADDR_W  destination of instruction in EX
- EX_BranchTaken  input  1  branch/jump resolved taken in EX this cycle
- Mem_Busy  input  1  data memory not ready; pipeline must freeze
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register load enable
- IF_ID_Flush  output  1  clear IF/ID to NOP
- ID_EX_Flush  output  1  clear ID/EX control (bubble)
- Pipe_Hold  output  1  hold EX/MEM and MEM/WB registers
- Stall_Count  output  CNT_W  bubbles inserted (feature)
- Flush_Count  output  CNT_W  branch squashes (feature)
- Hold_Count  output  CNT_W  memory-hold cycles (feature)

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Outputs are combinational from the state register and current inputs.
- While reset=1: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, Pipe_Hold=0. State goes to RUN, remaining-bubble counter goes to 0, statistics counters go to 0.
- States: RUN, LU_STALL.
- Hazard detect: lu = ID_EX_MemRead && ID_EX_Rd!=0 && ((IF_ID_UseRS1 && ID_EX_Rd==IF_ID_RS1) || (IF_ID_UseRS2 && ID_EX_Rd==IF_ID_RS2)).
- Priority, per cycle, in this order:
  - Mem_Busy=1:
    - PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=0, Pipe_Hold=1.
    - State and counter frozen. EX_BranchTaken and lu are ignored.
  - EX_BranchTaken=1:
    - PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, Pipe_Hold=0.
    - Next state RUN, counter cleared. This aborts any LU_STALL and overrides a simultaneous lu, because the load's consumer is squashed.
  - State LU_STALL:
    - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
    - If counter==1, next state is RUN; otherwise decrement the counter.
  - State RUN with lu=1:
    - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
    - If STALL_CYCLES>1, load counter with STALL_CYCLES-1 and go to LU_STALL; otherwise stay in RUN.
  - Otherwise: PCWrite=1, IF_ID_Write=1, both flushes 0, Pipe_Hold=0.
- A load-use hazard therefore inserts exactly STALL_CYCLES bubbles, excluding Mem_Busy cycles, which stretch the stall without consuming bubbles.
- No re-detection occurs in LU_STALL: the bubble clears ID_EX_MemRead.
- Rd=x0 never stalls.
- Back-to-back loads with dependency chains each stall independently, once the previous stall ends.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Stall_Count increments on each non-busy cycle with ID_EX_Flush=1 due to load-use (RUN with lu, or LU_STALL).
  - Flush_Count increments on each non-busy EX_BranchTaken cycle.
  - Hold_Count increments on each Mem_Busy cycle.
  - All counters saturate at 2^CNT_W-1 and clear on reset.
- Undefined: counter ports exist, are driven constant 0, and no counter flops are built.

Test Plan:
- ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_RS1=5, UseRS1=1, STALL_CYCLES=1 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle (MemRead=0) all enables 1, flushes 0.
- Same hazard with STALL_CYCLES=3 and MemRead dropping after cycle 1 -> exactly 3 consecutive bubble cycles, then RUN; with stats, Stall_Count=3.
- ID_EX_Rd=0, RS1=0, MemRead=1 -> no stall; also the RS2 match with UseRS2=0 -> no stall.
- Load-use hazard and EX_BranchTaken=1 in the same cycle -> PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1; state RUN, no further bubbles; Flush_Count=1.
- STALL_CYCLES=3, Mem_Busy=1 for 2 cycles mid-stall -> Pipe_Hold=1, all enables 0, flushes 0 during busy; remaining bubbles resume after, 3 bubbles total; Hold_Count=2.
- Reset asserted during LU_STALL -> same-cycle outputs forced to reset values; after release, state RUN with PCWrite=1 and counters 0.
